// File: rtl/product_window_stats.sv
// Reduces every WINDOW valid product samples to sum/max/min/mean and presents
// the result on a valid/ready port. A completion that cannot be delivered is dropped and flags overrun.
module product_window_stats #(
    parameter int WINDOW = 8,
    parameter int DATA_W = 8
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [DATA_W-1:0]             y,
    input  logic                          y_valid,
    input  logic                          clear,
    input  logic                          out_ready,
    output logic                          out_valid,
    output logic [DATA_W+$clog2(WINDOW)-1:0] sum,
    output logic [DATA_W-1:0]             max,
    output logic [DATA_W-1:0]             min,
    output logic [DATA_W-1:0]             mean,
    output logic [$clog2(WINDOW):0]       fill,
    output logic                          overrun
);

    localparam int CNT_W = $clog2(WINDOW);
    localparam int SUM_W = DATA_W + CNT_W;
    localparam logic [CNT_W:0] LAST = (CNT_W+1)'(WINDOW - 1);

    logic [SUM_W-1:0]  acc_sum;
    logic [DATA_W-1:0] acc_max;
    logic [DATA_W-1:0] acc_min;

    logic              take;
    logic              done;
    logic [SUM_W-1:0]  nxt_sum;
    logic [DATA_W-1:0] nxt_max;
    logic [DATA_W-1:0] nxt_min;

    // Values the accumulators would hold after taking this cycle's sample.
    always_comb begin
        take    = y_valid && !clear;
        done    = take && (fill == LAST);
        nxt_sum = SUM_W'(y);
        nxt_max = y;
        nxt_min = y;
        if (fill != '0) begin
            nxt_sum = acc_sum + SUM_W'(y);
            nxt_max = (y > acc_max) ? y : acc_max;
            nxt_min = (y < acc_min) ? y : acc_min;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            acc_sum   <= '0;
            acc_max   <= '0;
            acc_min   <= '0;
            fill      <= '0;
            out_valid <= 1'b0;
            sum       <= '0;
            max       <= '0;
            min       <= '0;
            mean      <= '0;
            overrun   <= 1'b0;
        end else begin
            if (clear) begin
                acc_sum <= '0;
                acc_max <= '0;
                acc_min <= '0;
                fill    <= '0;
                overrun <= 1'b0;
            end else if (take) begin
                acc_sum <= nxt_sum;
                acc_max <= nxt_max;
                acc_min <= nxt_min;
                fill    <= done ? '0 : fill + (CNT_W+1)'(1);
            end

            if (out_valid && out_ready)
                out_valid <= 1'b0;

            // The held slot frees up on a transfer edge, so a same-edge completion may load.
            if (done) begin
                if (!out_valid || out_ready) begin
                    out_valid <= 1'b1;
                    sum       <= nxt_sum;
                    max       <= nxt_max;
                    min       <= nxt_min;
                    mean      <= nxt_sum[SUM_W-1:CNT_W];
                end else begin
                    overrun   <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_product_window_stats.sv
// Directed test of product_window_stats at WINDOW=4 with hand-computed results.
module tb_product_window_stats;

    localparam int WINDOW = 4;
    localparam int DATA_W = 8;

    logic        clock = 1'b0;
    logic        reset;
    logic [7:0]  y;
    logic        y_valid;
    logic        clear;
    logic        out_ready;
    logic        out_valid;
    logic [9:0]  sum;
    logic [7:0]  max;
    logic [7:0]  min;
    logic [7:0]  mean;
    logic [2:0]  fill;
    logic        overrun;

    int tests = 0;
    int fails = 0;

    product_window_stats #(.WINDOW(WINDOW), .DATA_W(DATA_W)) dut (
        .clock(clock), .reset(reset), .y(y), .y_valid(y_valid), .clear(clear),
        .out_ready(out_ready), .out_valid(out_valid), .sum(sum), .max(max),
        .min(min), .mean(mean), .fill(fill), .overrun(overrun)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_res(input string tag, input int v, input int s, input int mx,
                           input int mn, input int me, input int ov);
        chk({tag, ".out_valid"}, 32'(out_valid), 32'(v));
        chk({tag, ".sum"},       32'(sum),       32'(s));
        chk({tag, ".max"},       32'(max),       32'(mx));
        chk({tag, ".min"},       32'(min),       32'(mn));
        chk({tag, ".mean"},      32'(mean),      32'(me));
        chk({tag, ".overrun"},   32'(overrun),   32'(ov));
    endtask

    task automatic send(input int v);
        y_valid = 1'b1;
        y = 8'(v);
        tick();
        y_valid = 1'b0;
    endtask

    initial begin
        reset = 1'b0; y = '0; y_valid = 1'b0; clear = 1'b0; out_ready = 1'b0;
        tick(); tick();
        chk_res("reset", 0, 0, 0, 0, 0, 0);
        chk("reset.fill", 32'(fill), 0);
        reset = 1'b1;

        // Basic window
        out_ready = 1'b1;
        send(10);
        chk("basic.fill1", 32'(fill), 1);
        send(20); send(30); send(40);
        chk_res("basic", 1, 100, 40, 10, 25, 0);
        chk("basic.fill0", 32'(fill), 0);
        tick();
        chk("basic.drop", 32'(out_valid), 0);

        // Saturating values with idle gaps
        for (int i = 0; i < 4; i++) begin
            send(255);
            chk($sformatf("sat.fill%0d", i), 32'(fill), 32'((i + 1) % 4));
            if (i == 3) chk_res("sat", 1, 1020, 255, 255, 255, 0);
            tick();
        end
        chk("sat.drop", 32'(out_valid), 0);

        // Backpressure and overrun
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) send(5);
        chk_res("bp.first", 1, 20, 5, 5, 5, 0);
        for (int i = 0; i < 4; i++) send(5);
        chk_res("bp.overrun", 1, 20, 5, 5, 5, 1);
        out_ready = 1'b1;
        tick();
        chk("bp.xfer", 32'(out_valid), 0);
        chk("bp.sticky", 32'(overrun), 1);
        for (int i = 0; i < 4; i++) send(7);
        chk_res("bp.third", 1, 28, 7, 7, 7, 1);
        out_ready = 1'b0;
        tick();
        chk_res("bp.hold", 1, 28, 7, 7, 7, 1);

        // Clear leaves a held result alone but drops overrun
        clear = 1'b1;
        tick();
        clear = 1'b0;
        chk_res("clr.held", 1, 28, 7, 7, 7, 0);

        // Accept and complete on the same edge
        send(9); send(9); send(9);
        chk_res("sim.wait", 1, 28, 7, 7, 7, 0);
        out_ready = 1'b1;
        send(13);
        chk_res("sim.load", 1, 40, 13, 9, 10, 0);
        tick();
        chk("sim.drop", 32'(out_valid), 0);

        // Clear mid-window
        send(50); send(60);
        chk("mid.fill2", 32'(fill), 2);
        clear = 1'b1; y_valid = 1'b1; y = 8'd99;
        tick();
        clear = 1'b0; y_valid = 1'b0;
        chk("mid.fill0", 32'(fill), 0);
        chk("mid.noout", 32'(out_valid), 0);
        for (int i = 0; i < 4; i++) send(1);
        chk_res("mid", 1, 4, 1, 1, 1, 0);
        tick();

        // Reset mid-operation
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) send(2);
        for (int i = 0; i < 3; i++) send(3);
        chk("rst.pre_fill", 32'(fill), 3);
        chk("rst.pre_valid", 32'(out_valid), 1);
        reset = 1'b0; y_valid = 1'b1; y = 8'd3; clear = 1'b1; out_ready = 1'b1;
        tick();
        y_valid = 1'b0; clear = 1'b0;
        chk_res("rst", 0, 0, 0, 0, 0, 0);
        chk("rst.fill", 32'(fill), 0);
        reset = 1'b1;
        send(4); send(8); send(12); send(16);
        chk_res("rst.clean", 1, 40, 16, 4, 10, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/product_window_stats.md
# product_window_stats

Downstream consumer of the (a+b)*(c+d) arithmetic pipeline. Accepts its 8-bit product stream with a valid qualifier and reduces every WINDOW consecutive valid samples to sum, maximum, minimum and mean. Presents each window result on a valid/ready output port and holds it until accepted. The input cannot be stalled, so a result that cannot be delivered is dropped and flagged.

## Interface
- WINDOW, 8: samples per window; power of two, 2..256.
- DATA_W, 8: product width; matches the upstream y output.
- SUM_W, DATA_W + log2(WINDOW) (11 by default): derived, not overridable.
- clock  input  1  single clock; all state updates on its rising edge.
- reset  input  1  one clock; reset is synchronous and active-low.
- y  input  DATA_W  product sample from the arithmetic stage.
- y_valid  input  1  y carries a sample this cycle.
- clear  input  1  synchronous; discards the partial window and clears overrun.
- out_ready  input  1  consumer accepts the result this cycle.
- out_valid  output  1  window result is held on the outputs.
- sum  output  SUM_W  unsigned sum of the window's samples.
- max  output  DATA_W  largest sample in the window.
- min  output  DATA_W  smallest sample in the window.
- mean  output  DATA_W  sum >> log2(WINDOW), truncated.
- fill  output  log2(WINDOW)+1  samples accepted in the current partial window.
- overrun  output  1  sticky; a completed window was dropped.

## Operation
- Reset (reset=0 at an edge): out_valid, sum, max, min, mean, fill and overrun all go to 0. Internal accumulators also clear. reset overrides clear and every other input.
- Sample acceptance: sample taken on every edge with y_valid=1 and clear=0. Gaps in y_valid are allowed; no ordering or timeout exists.
- Accumulators:
  - first sample of a window: acc_sum=y, acc_max=y, acc_min=y.
  - later samples: acc_sum+=y, acc_max=max(acc_max,y), acc_min=min(acc_min,y).
  - All comparisons are unsigned. SUM_W cannot overflow (WINDOW*(2^DATA_W-1) fits).
- Window completion: the sample that brings the count to WINDOW completes the window. Final values including that sample are transferred to the output registers. fill returns to 0, and the next sample starts a fresh window.
- Output handshake: transfer occurs on an edge with out_valid=1 and out_ready=1. The outputs hold stable while out_valid=1 and out_ready=0. out_valid drops after a transfer unless a new window completes on the same edge.
- Window completes while out_valid=0, or while out_valid=1 and out_ready=1: the new result loads and out_valid is 1 after the edge.
- Window completes while out_valid=1 and out_ready=0: the new result is discarded, the held result is unchanged, and overrun is set.
- clear=1:
  - fill and the accumulators reset and the y sample is ignored that cycle.
  - overrun is cleared.
  - A held output result, out_valid and the handshake are unaffected.

## Timing
- Result latency: out_valid rises on the edge that accepts the WINDOW-th sample, i.e. visible in the cycle after the last y_valid.
- Throughput: one sample per cycle, indefinitely, provided out_ready=1 at least once every WINDOW cycles.
- fill updates on the same edge as sample acceptance. It reads 0..WINDOW-1 and never shows WINDOW.
- overrun sets on the edge of the dropped completion. It clears only via reset or clear.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Test plan
- Basic window: WINDOW=4, out_ready=1, y=10,20,30,40 on consecutive cycles -> one cycle after 40: out_valid=1, sum=100, max=40, min=10, mean=25. out_valid drops the next cycle.
- Saturating values with gaps: WINDOW=4, y=255 four times with idle cycles between -> sum=1020, max=255, min=255, mean=255, fill stepping 1,2,3,0.
- Backpressure and overrun:
  - Setup: out_ready=0, stream 8 samples of value 5 then 4 samples of 7.
  - Required: first result (sum=20) holds unchanged and overrun=1 after the second completion.
  - Then: raising out_ready transfers sum=20, and the third window (sum=28) is delivered afterwards.
- Simultaneous accept and complete: held result present, out_ready=1 on the same edge the next window completes -> out_valid stays 1, the new values load, overrun stays 0.
- Clear mid-window: 2 samples (50, 60), clear=1 together with y_valid=1 (y=99), then 4 samples of 1 -> sum=4, max=1, min=1, overrun=0.
- Reset mid-operation: reset=0 with fill=3 and out_valid=1 -> next cycle all outputs 0. The following 4 samples form a clean window.
